// File: rtl/pulse_period_meter_pkg.sv
// rtl/pulse_period_meter_pkg.sv - shared state encoding and default sizing for the period meter
// Purpose: state encoding and 50 MHz default parameters used by pulse_period_meter.
// Ports: none (package).
package pulse_period_meter_pkg;

  // Measurement states.
  typedef enum logic [1:0] {
    S_WAIT_RISE = 2'd0,  // idle, waiting for the first rising edge
    S_HIGH      = 2'd1,  // signal high, waiting for the fall
    S_LOW       = 2'd2   // signal low, waiting for the closing rise
  } state_t;

  // 2^26 cycles is about 1.34 s at 50 MHz.
  localparam int DEF_CNT_W       = 26;
  // 1 s at 50 MHz.
  localparam int DEF_TIMEOUT_CYC = 50_000_000;

endpackage

// File: rtl/pulse_period_meter.sv
// rtl/pulse_period_meter.sv - measures high time and period from edge strobes
// Purpose: counts clock cycles between edge strobes and reports high time and
//          full period once per complete period; abandons stalled measurements.
// Ports:
//   clk      - system clock (50 MHz)
//   rst_n    - synchronous active-low reset
//   iEn      - measurement enable; low forces idle
//   iPos     - one-cycle rising-edge strobe
//   iNeg     - one-cycle falling-edge strobe
//   oHigh    - last measured high time, cycles
//   oPeriod  - last measured period, cycles
//   oValid   - one-cycle strobe, oHigh/oPeriod updated
//   oTimeout - one-cycle strobe, measurement abandoned
module pulse_period_meter
  import pulse_period_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iEn,
  input  logic             iPos,
  input  logic             iNeg,
  output logic [CNT_W-1:0] oHigh,
  output logic [CNT_W-1:0] oPeriod,
  output logic             oValid,
  output logic             oTimeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] high_len, high_len_next;
  logic [CNT_W-1:0] high_next, period_next;
  logic             valid_next, timeout_next;
  logic             pos_only, neg_only, timed_out;

  // Coincident strobes cannot come from a healthy edge detector; treat them as noise.
  assign pos_only  = iPos & ~iNeg;
  assign neg_only  = iNeg & ~iPos;
  // >= rather than == so a fall landing exactly on the limit cannot push the
  // LOW count past the limit and let it run to wrap.
  assign timed_out = (cnt >= TIMEOUT_VAL);

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    high_len_next = high_len;
    high_next     = oHigh;
    period_next   = oPeriod;
    valid_next    = 1'b0;
    timeout_next  = 1'b0;

    if (!iEn) begin
      state_next = S_WAIT_RISE;
      cnt_next   = '0;
    end else begin
      case (state)
        S_WAIT_RISE: begin
          if (pos_only) begin
            state_next = S_HIGH;
            cnt_next   = ONE;
          end
        end
        S_HIGH: begin
          if (pos_only) begin
            // Missed fall: restart the high phase from this rise.
            cnt_next = ONE;
          end else if (neg_only) begin
            high_len_next = cnt;
            state_next    = S_LOW;
            cnt_next      = cnt + ONE;
          end else if (timed_out) begin
            timeout_next = 1'b1;
            state_next   = S_WAIT_RISE;
            cnt_next     = '0;
          end else begin
            cnt_next = cnt + ONE;
          end
        end
        S_LOW: begin
          if (pos_only) begin
            // Closing rise also opens the next period, so results are back-to-back.
            high_next   = high_len;
            period_next = cnt;
            valid_next  = 1'b1;
            state_next  = S_HIGH;
            cnt_next    = ONE;
          end else if (timed_out) begin
            timeout_next = 1'b1;
            state_next   = S_WAIT_RISE;
            cnt_next     = '0;
          end else begin
            cnt_next = cnt + ONE;
          end
        end
        default: begin
          state_next = S_WAIT_RISE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_WAIT_RISE;
      cnt      <= '0;
      high_len <= '0;
      oHigh    <= '0;
      oPeriod  <= '0;
      oValid   <= 1'b0;
      oTimeout <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      high_len <= high_len_next;
      oHigh    <= high_next;
      oPeriod  <= period_next;
      oValid   <= valid_next;
      oTimeout <= timeout_next;
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// tb/tb_pulse_period_meter.sv - directed self-checking bench for pulse_period_meter
module tb_pulse_period_meter;

  localparam int W  = 26;
  localparam int TO = 100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iEn;
  logic         iPos;
  logic         iNeg;
  logic [W-1:0] oHigh;
  logic [W-1:0] oPeriod;
  logic         oValid;
  logic         oTimeout;

  int vecs = 0;
  int errs = 0;

  pulse_period_meter #(.CNT_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .iEn      (iEn),
    .iPos     (iPos),
    .iNeg     (iNeg),
    .oHigh    (oHigh),
    .oPeriod  (oPeriod),
    .oValid   (oValid),
    .oTimeout (oTimeout)
  );

  always #5 clk = ~clk;

  // After tick the outputs show what the just-passed edge registered.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; iEn = 1'b1; iPos = 1'b0; iNeg = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive_pos();
    iPos = 1'b1; tick(); iPos = 1'b0;
  endtask

  task automatic drive_neg();
    iNeg = 1'b1; tick(); iNeg = 1'b0;
  endtask

  // Idle cycles; returns how many strobes (valid or timeout) appeared.
  task automatic run_idle(input int n, output int strobes);
    strobes = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (oValid || oTimeout) strobes++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iEn = 1'b1; iPos = 1'b0; iNeg = 1'b0;
    tick();
    rst_n = 1'b1;
    vecs++;
    if (oHigh !== '0 || oPeriod !== '0 || oValid !== 1'b0 || oTimeout !== 1'b0) begin
      errs++;
      $display("FAIL reset: high=%0d period=%0d valid=%b timeout=%b expected 0 0 0 0",
               oHigh, oPeriod, oValid, oTimeout);
    end
  endtask

  task automatic test_periodic();
    int k, n;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      drive_pos();
      vecs++;
      if (oValid !== 1'(p > 0)) begin
        errs++;
        $display("FAIL periodic_valid[%0d]: valid=%b expected %b", p, oValid, p > 0);
      end
      if (p > 0) begin
        vecs++;
        if (oHigh !== W'(5) || oPeriod !== W'(12)) begin
          errs++;
          $display("FAIL periodic_result[%0d]: high=%0d period=%0d expected 5 12", p, oHigh, oPeriod);
        end
      end
      if (p < 4) begin
        n = 0;
        run_idle(4, k); n += k;
        drive_neg();    n += int'(oValid | oTimeout);
        run_idle(6, k); n += k;
        vecs++;
        if (n != 0) begin
          errs++;
          $display("FAIL periodic_quiet[%0d]: strobes=%0d expected 0", p, n);
        end
      end
    end
  endtask

  task automatic test_min_pulse();
    do_reset();
    for (int p = 0; p < 6; p++) begin
      drive_pos();
      vecs++;
      if (oValid !== 1'(p > 0) || (p > 0 && (oHigh !== W'(1) || oPeriod !== W'(2)))) begin
        errs++;
        $display("FAIL min_pulse[%0d]: valid=%b high=%0d period=%0d expected %b 1 2",
                 p, oValid, oHigh, oPeriod, p > 0);
      end
      drive_neg();
      vecs++;
      if (oValid !== 1'b0) begin
        errs++;
        $display("FAIL min_pulse_fall[%0d]: valid=%b expected 0", p, oValid);
      end
    end
  endtask

  task automatic test_timeout();
    int k, to_cnt, to_at, v_cnt;
    do_reset();
    // Seed results with H=2, L=3 so the hold check has nonzero values.
    drive_pos(); run_idle(1, k); drive_neg(); run_idle(2, k);
    drive_pos();
    vecs++;
    if (oValid !== 1'b1 || oHigh !== W'(2) || oPeriod !== W'(5)) begin
      errs++;
      $display("FAIL timeout_seed: valid=%b high=%0d period=%0d expected 1 2 5", oValid, oHigh, oPeriod);
    end
    // Case 0: stuck high from the rise above. Case 1: one fall, then stuck low.
    for (int c = 0; c < 2; c++) begin
      if (c == 1) drive_pos();
      to_cnt = 0; to_at = -1; v_cnt = 0;
      for (int i = 1; i <= 110; i++) begin
        iNeg = (c == 1 && i == 3);
        tick();
        iNeg = 1'b0;
        if (oTimeout) begin to_cnt++; if (to_at < 0) to_at = i; end
        if (oValid) v_cnt++;
      end
      vecs++;
      if (to_cnt != 1 || to_at != TO || v_cnt != 0) begin
        errs++;
        $display("FAIL timeout[%0d]: pulses=%0d at=%0d valids=%0d expected 1 at %0d with 0 valids",
                 c, to_cnt, to_at, v_cnt, TO);
      end
      vecs++;
      if (oHigh !== W'(2) || oPeriod !== W'(5)) begin
        errs++;
        $display("FAIL timeout_hold[%0d]: high=%0d period=%0d expected 2 5", c, oHigh, oPeriod);
      end
    end
    // Back in WAIT_RISE, so a rise only opens a measurement.
    drive_pos();
    vecs++;
    if (oValid !== 1'b0) begin
      errs++;
      $display("FAIL timeout_idle: valid=%b expected 0", oValid);
    end
  endtask

  task automatic test_missed_fall();
    int k, n;
    do_reset();
    n = 0;
    drive_pos();    n += int'(oValid);
    run_idle(9, k); n += k;
    drive_pos();    n += int'(oValid);
    run_idle(2, k); n += k;
    drive_neg();    n += int'(oValid);
    run_idle(3, k); n += k;
    vecs++;
    if (n != 0) begin
      errs++;
      $display("FAIL missed_fall_quiet: strobes=%0d expected 0", n);
    end
    drive_pos();
    vecs++;
    if (oValid !== 1'b1 || oHigh !== W'(3) || oPeriod !== W'(7)) begin
      errs++;
      $display("FAIL missed_fall: valid=%b high=%0d period=%0d expected 1 3 7", oValid, oHigh, oPeriod);
    end
  endtask

  task automatic test_en_deassert();
    int k, n;
    do_reset();
    drive_pos(); run_idle(1, k); drive_neg(); run_idle(2, k);
    drive_pos();
    vecs++;
    if (oValid !== 1'b1 || oHigh !== W'(2) || oPeriod !== W'(5)) begin
      errs++;
      $display("FAIL en_seed: valid=%b high=%0d period=%0d expected 1 2 5", oValid, oHigh, oPeriod);
    end
    run_idle(1, k); drive_neg();
    iEn = 1'b0;
    run_idle(3, n);
    iEn = 1'b1;
    vecs++;
    if (n != 0 || oHigh !== W'(2) || oPeriod !== W'(5)) begin
      errs++;
      $display("FAIL en_hold: strobes=%0d high=%0d period=%0d expected 0 2 5", n, oHigh, oPeriod);
    end
    // Rise on the first re-enabled cycle opens a fresh measurement, H=4, L=2.
    n = 0;
    drive_pos();    n += int'(oValid);
    run_idle(3, k); n += k;
    drive_neg();    n += int'(oValid);
    run_idle(1, k); n += k;
    vecs++;
    if (n != 0) begin
      errs++;
      $display("FAIL en_reenable_quiet: strobes=%0d expected 0", n);
    end
    drive_pos();
    vecs++;
    if (oValid !== 1'b1 || oHigh !== W'(4) || oPeriod !== W'(6)) begin
      errs++;
      $display("FAIL en_reenable: valid=%b high=%0d period=%0d expected 1 4 6", oValid, oHigh, oPeriod);
    end
  endtask

  task automatic test_reset_mid();
    int k, n;
    do_reset();
    drive_pos(); run_idle(1, k); drive_neg(); run_idle(2, k); drive_pos();
    run_idle(1, k);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    vecs++;
    if (oHigh !== '0 || oPeriod !== '0 || oValid !== 1'b0 || oTimeout !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid: high=%0d period=%0d valid=%b timeout=%b expected 0 0 0 0",
               oHigh, oPeriod, oValid, oTimeout);
    end
    // Stray fall in WAIT_RISE is ignored; then H=3, L=2.
    n = 0;
    drive_neg();    n += int'(oValid);
    run_idle(1, k); n += k;
    drive_pos();    n += int'(oValid);
    run_idle(2, k); n += k;
    drive_neg();    n += int'(oValid);
    run_idle(1, k); n += k;
    vecs++;
    if (n != 0) begin
      errs++;
      $display("FAIL reset_mid_quiet: strobes=%0d expected 0", n);
    end
    drive_pos();
    vecs++;
    if (oValid !== 1'b1 || oHigh !== W'(3) || oPeriod !== W'(5)) begin
      errs++;
      $display("FAIL reset_mid_next: valid=%b high=%0d period=%0d expected 1 3 5", oValid, oHigh, oPeriod);
    end
  endtask

  task automatic test_simultaneous();
    int k;
    do_reset();
    drive_pos(); run_idle(1, k); drive_neg();
    iPos = 1'b1; iNeg = 1'b1; tick(); iPos = 1'b0; iNeg = 1'b0;
    vecs++;
    if (oValid !== 1'b0) begin
      errs++;
      $display("FAIL simultaneous_ignored: valid=%b expected 0", oValid);
    end
    run_idle(1, k);
    drive_pos();
    vecs++;
    if (oValid !== 1'b1 || oHigh !== W'(2) || oPeriod !== W'(5)) begin
      errs++;
      $display("FAIL simultaneous: valid=%b high=%0d period=%0d expected 1 2 5", oValid, oHigh, oPeriod);
    end
  endtask

  initial begin
    rst_n = 1'b0; iEn = 1'b1; iPos = 1'b0; iNeg = 1'b0;
    test_reset();
    test_periodic();
    test_min_pulse();
    test_timeout();
    test_missed_fall();
    test_en_deassert();
    test_reset_mid();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
